// File: rtl/mandel_iter_engine.sv
// Sequential Mandelbrot iteration engine: iterates z = z^2 + c from z = 0 for one
// pixel in signed Q10.21 and reports the escape iteration count.

module mandel_fixmul (
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic signed [31:0] p
);
  logic signed [63:0] full;

  // Q10.21 x Q10.21 -> Q20.42, truncated (floor) back to Q10.21
  assign full = 64'(a) * 64'(b);
  assign p    = 32'(full >>> 21);
endmodule

module mandel_iter_engine #(
  parameter int unsigned MAX_ITER = 255,
  parameter int unsigned ITER_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       c_re,
  input  logic [31:0]       c_im,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_count,
  output logic              escaped
);
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MULT  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // |x| or |y| at or beyond 16.0 would overflow the squares
  localparam logic signed [DATA_W-1:0] GUARD_POS = 32'sh0200_0000;
  localparam logic signed [DATA_W-1:0] GUARD_NEG = 32'shFE00_0000;
  localparam logic [DATA_W:0]          ESC_LIM   = 33'h0_0080_0000;

  logic [1:0]               state_q, state_d;
  logic signed [DATA_W-1:0] cr_q, cr_d, ci_q, ci_d;
  logic signed [DATA_W-1:0] x_q, x_d, y_q, y_d;
  logic signed [DATA_W-1:0] xx_q, xx_d, yy_q, yy_d, xy_q, xy_d;
  logic [ITER_W-1:0]        iter_q, iter_d;
  logic                     busy_d, done_d, escaped_d;
  logic [ITER_W-1:0]        iter_count_d;

  logic signed [DATA_W-1:0] xx_c, yy_c, xy_c;
  logic [DATA_W:0]          mag_sum_c;
  logic                     guard_c;

  mandel_fixmul u_mul_xx (.a(x_q), .b(x_q), .p(xx_c));
  mandel_fixmul u_mul_yy (.a(y_q), .b(y_q), .p(yy_c));
  mandel_fixmul u_mul_xy (.a(x_q), .b(y_q), .p(xy_c));

  assign mag_sum_c = {1'b0, xx_q} + {1'b0, yy_q};
  assign guard_c   = (x_q >= GUARD_POS) || (x_q <= GUARD_NEG) ||
                     (y_q >= GUARD_POS) || (y_q <= GUARD_NEG);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cr_q       <= '0;
      ci_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      xx_q       <= '0;
      yy_q       <= '0;
      xy_q       <= '0;
      iter_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      iter_count <= '0;
      escaped    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cr_q       <= cr_d;
      ci_q       <= ci_d;
      x_q        <= x_d;
      y_q        <= y_d;
      xx_q       <= xx_d;
      yy_q       <= yy_d;
      xy_q       <= xy_d;
      iter_q     <= iter_d;
      busy       <= busy_d;
      done       <= done_d;
      iter_count <= iter_count_d;
      escaped    <= escaped_d;
    end
  end

  // Next-state and datapath update; outputs are derived from the next state
  always_comb begin
    state_d      = state_q;
    cr_d         = cr_q;
    ci_d         = ci_q;
    x_d          = x_q;
    y_d          = y_q;
    xx_d         = xx_q;
    yy_d         = yy_q;
    xy_d         = xy_q;
    iter_d       = iter_q;
    iter_count_d = iter_count;
    escaped_d    = escaped;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cr_d         = c_re;
          ci_d         = c_im;
          x_d          = '0;
          y_d          = '0;
          iter_d       = '0;
          iter_count_d = '0;
          escaped_d    = 1'b0;
          state_d      = S_MULT;
        end
      end
      S_MULT: begin
        xx_d    = xx_c;
        yy_d    = yy_c;
        xy_d    = xy_c;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (guard_c || (mag_sum_c > ESC_LIM)) begin
          escaped_d    = 1'b1;
          iter_count_d = iter_q;
          state_d      = S_DONE;
        end else if (iter_q == ITER_W'(MAX_ITER)) begin
          escaped_d    = 1'b0;
          iter_count_d = iter_q;
          state_d      = S_DONE;
        end else begin
          x_d     = xx_q - yy_q + cr_q;
          y_d     = (xy_q <<< 1) + ci_q;
          iter_d  = iter_q + ITER_W'(1);
          state_d = S_MULT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end
endmodule

// File: tb/tb_mandel_iter_engine.sv
// Scoreboard bench for mandel_iter_engine: expected results come from a plain
// arithmetic Mandelbrot model and are checked by a monitor on every done pulse.

module tb_mandel_iter_engine;
  localparam int unsigned MAX_ITER = 255;
  localparam int unsigned ITER_W   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [31:0]       c_re, c_im;
  logic              busy, done, escaped;
  logic [ITER_W-1:0] iter_count;

  mandel_iter_engine #(.MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst(rst), .start(start), .c_re(c_re), .c_im(c_im),
    .busy(busy), .done(done), .iter_count(iter_count), .escaped(escaped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     n;
    bit     esc;
    longint acc;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   e_mon;
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  bit     in_flight = 0;
  bit     busy_drop = 0;
  bit     have_last = 0;
  int     last_n = 0;
  bit     last_esc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic signed [31:0] fmul(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    longint p;
    p = longint'(a) * longint'(b);
    return 32'(p >>> 21);
  endfunction

  // Reference: escape-time iteration of z = z^2 + c in Q10.21
  function automatic void ref_model(input logic [31:0] cr, input logic [31:0] ci,
                                    output int n, output bit esc);
    logic signed [31:0] x, y, xx, yy, xy;
    longint lx, ly, mag;
    x = 0; y = 0; n = 0; esc = 0;
    for (int it = 0; it <= int'(MAX_ITER); it++) begin
      xx = fmul(x, x); yy = fmul(y, y); xy = fmul(x, y);
      lx = longint'(x); ly = longint'(y);
      mag = longint'({32'b0, xx}) + longint'({32'b0, yy});
      n = it;
      if (lx >= 64'sd33554432 || lx <= -64'sd33554432 ||
          ly >= 64'sd33554432 || ly <= -64'sd33554432) begin
        esc = 1; return;
      end
      if (mag > 64'sd8388608) begin
        esc = 1; return;
      end
      if (it == int'(MAX_ITER)) begin
        esc = 0; return;
      end
      x = xx - yy + signed'(cr);
      y = xy * 2 + signed'(ci);
    end
  endfunction

  // Monitor: pop and compare on every done pulse
  always @(negedge clk) begin
    if (in_flight && !busy) busy_drop = 1;
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: done=1 with no job outstanding (t=%0t)", $time);
      end else begin
        e_mon = exp_q.pop_front();
        check("iter_count", longint'(iter_count), longint'(e_mon.n));
        check("escaped", longint'(escaped), longint'(e_mon.esc));
        check("latency", cyc - e_mon.acc, longint'(2 * e_mon.n + 2));
        check("busy_held", longint'(busy_drop), 0);
        in_flight = 0; busy_drop = 0;
        last_n = e_mon.n; last_esc = e_mon.esc; have_last = 1;
      end
    end
  end

  task automatic wait_done();
    int k = 0;
    while (!done && k < int'(2 * MAX_ITER + 20)) begin
      @(negedge clk); k++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: no done within %0d cycles (t=%0t)", k, $time);
      exp_q.delete(); in_flight = 0; busy_drop = 0;
    end
  endtask

  // b2b: called at the negedge of a done cycle, start asserted during it
  task automatic run_job(input logic [31:0] cr, input logic [31:0] ci,
                         input bit b2b, input bit poke);
    int n; bit esc; int k;
    ref_model(cr, ci, n, esc);
    if (!b2b) begin
      k = 0;
      @(negedge clk);
      while (busy && k < 1000) begin @(negedge clk); k++; end
      if (have_last) begin
        check("hold_count", longint'(iter_count), longint'(last_n));
        check("hold_escaped", longint'(escaped), longint'(last_esc));
      end
    end
    start = 1; c_re = cr; c_im = ci;
    if (b2b) begin
      @(posedge clk); #1;
      check("b2b_idle_gap", longint'(busy), 0);
    end
    @(posedge clk); #1;
    start = 0; c_re = $urandom; c_im = $urandom;
    exp_q.push_back('{n, esc, cyc});
    in_flight = 1; busy_drop = 0;
    @(negedge clk);
    check("accept_busy", longint'(busy), 1);
    check("accept_clear", longint'({iter_count, escaped}), 0);
    if (poke) begin
      repeat (2) @(negedge clk);
      start = 1; c_re = 32'h0040_0000; c_im = 32'h0010_0000;
      repeat (4) @(negedge clk);
      start = 0;
    end
    wait_done();
  endtask

  logic [31:0] rcr, rci;

  initial begin
    rst = 1; start = 0; c_re = '0; c_im = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_state", longint'({busy, done, iter_count, escaped}), 0);

    run_job(32'h0000_0000, 32'h0000_0000, 0, 1);
    run_job(32'h0040_0000, 32'h0000_0000, 0, 0);
    run_job(32'h0020_0000, 32'h0000_0000, 0, 0);
    run_job(32'hFFC0_0000, 32'h0000_0000, 0, 0);
    run_job(32'h0000_0000, 32'h0020_0000, 0, 0);
    run_job(32'h1F40_0000, 32'h0000_0000, 0, 0);
    run_job(32'hFFE0_0000, 32'h0008_0000, 1, 0);

    // Abort a c = 0 job around iteration 10
    @(negedge clk);
    while (busy) @(negedge clk);
    start = 1; c_re = '0; c_im = '0;
    @(posedge clk); #1;
    start = 0;
    exp_q.push_back('{int'(MAX_ITER), 1'b0, cyc});
    in_flight = 1; busy_drop = 0;
    repeat (20) @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_q.delete(); in_flight = 0; busy_drop = 0; have_last = 0;
    @(negedge clk);
    check("abort_busy", longint'(busy), 0);
    check("abort_outputs", longint'({done, iter_count, escaped}), 0);
    begin
      int seen = 0;
      repeat (600) begin
        @(negedge clk);
        if (done) seen++;
      end
      check("abort_no_done", longint'(seen), 0);
    end

    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 5) begin
        rcr = $urandom; rci = $urandom;
      end else begin
        rcr = 32'($urandom_range(0, 32'h0070_0000)) - 32'h0050_0000;
        rci = 32'($urandom_range(0, 32'h0060_0000)) - 32'h0030_0000;
      end
      run_job(rcr, rci, (i % 3 == 1), 0);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
